// File: rtl/lvds_align_pkg.sv
// Shared types and constants for the LVDS word aligner.
package lvds_align_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StSlip,
    StSettle,
    StLocked,
    StFail
  } align_state_e;

  localparam logic [7:0] DefaultFramePattern = 8'h0F;

endpackage

// File: rtl/lvds_word_aligner.sv
// Trains ISERDES word boundaries by bitslipping until the frame lane shows the
// expected pattern, then tracks lock and forwards registered lane data.
module lvds_word_aligner
  import lvds_align_pkg::*;
#(
  parameter int unsigned       NUM_LANES       = 1,
  parameter int unsigned       WORD_W          = 8,
  parameter logic [WORD_W-1:0] FRAME_PATTERN   = WORD_W'(DefaultFramePattern),
  parameter int unsigned       SETTLE_CYCLES   = 8,
  parameter int unsigned       LOCK_MATCHES    = 16,
  parameter int unsigned       LOSS_MISMATCHES = 4
) (
  input  logic                          sample_clk,
  input  logic                          reset_n,
  input  logic                          train_en,
  input  logic [WORD_W-1:0]             frame_word,
  input  logic [NUM_LANES*WORD_W-1:0]   lane_words,
  output logic                          bitslip,
  output logic [NUM_LANES*WORD_W-1:0]   data_out,
  output logic                          data_valid,
  output logic                          aligned,
  output logic                          fail,
  output logic [$clog2(WORD_W):0]       slip_count,
  output logic [15:0]                   error_count
);

  localparam int unsigned SlipW   = $clog2(WORD_W) + 1;
  localparam int unsigned MatchW  = $clog2(LOCK_MATCHES + 1);
  localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned MissW   = $clog2(LOSS_MISMATCHES + 1);

  localparam logic [SlipW-1:0]   SlipMax    = SlipW'(WORD_W);
  localparam logic [MatchW-1:0]  MatchLast  = MatchW'(LOCK_MATCHES - 1);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);
  localparam logic [MissW-1:0]   MissLast   = MissW'(LOSS_MISMATCHES - 1);

  align_state_e                state_q, state_d;
  logic [SlipW-1:0]            slip_q, slip_d;
  logic [MatchW-1:0]           match_q, match_d;
  logic [SettleW-1:0]          settle_q, settle_d;
  logic [MissW-1:0]            miss_q, miss_d;
  logic [15:0]                 err_q, err_d;
  logic [NUM_LANES*WORD_W-1:0] data_q;
  logic                        frame_ok;

  assign frame_ok = (frame_word == FRAME_PATTERN);

  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    slip_d   = slip_q;
    match_d  = match_q;
    settle_d = settle_q;
    miss_d   = miss_q;
    err_d    = err_q;
    // Dropping train_en wins everywhere, including mid-pulse in StSlip.
    if (!train_en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d  = StCheck;
          slip_d   = '0;
          match_d  = '0;
          settle_d = '0;
          miss_d   = '0;
        end
        StCheck: begin
          if (frame_ok) begin
            if (match_q == MatchLast) begin
              state_d = StLocked;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
            state_d = (slip_q == SlipMax) ? StFail : StSlip;
          end
        end
        StSlip: begin
          slip_d   = slip_q + 1'b1;
          settle_d = '0;
          state_d  = StSettle;
        end
        StSettle: begin
          if (settle_q == SettleLast) begin
            settle_d = '0;
            state_d  = StCheck;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
        StLocked: begin
          if (frame_ok) begin
            miss_d = '0;
          end else begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (miss_q == MissLast) begin
              miss_d  = '0;
              state_d = StCheck;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end
        StFail:  state_d = StFail;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      slip_q   <= '0;
      match_q  <= '0;
      settle_q <= '0;
      miss_q   <= '0;
      err_q    <= '0;
      data_q   <= '0;
    end else begin
      slip_q   <= slip_d;
      match_q  <= match_d;
      settle_q <= settle_d;
      miss_q   <= miss_d;
      err_q    <= err_d;
      // Capture only while locked next cycle so data_out and data_valid move together.
      if (state_d == StLocked) data_q <= lane_words;
    end
  end

  always_comb begin
    bitslip    = 1'b0;
    aligned    = 1'b0;
    data_valid = 1'b0;
    fail       = 1'b0;
    unique case (state_q)
      StSlip:   bitslip = 1'b1;
      StLocked: begin
        aligned    = 1'b1;
        data_valid = 1'b1;
      end
      StFail:   fail = 1'b1;
      default:  ;
    endcase
  end

  assign data_out    = data_q;
  assign slip_count  = slip_q;
  assign error_count = err_q;

endmodule
